// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stage tag scoreboard producing EX forwarding selects and an ID load-use stall
module pipeline_hazard_unit #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              id_valid,
    input  logic [NSRC*AW-1:0]                id_src,
    input  logic [NSRC-1:0]                   id_src_use,
    input  logic [AW-1:0]                     id_rd,
    input  logic                              id_regwr,
    input  logic                              id_load,
    input  logic                              flush,
    input  logic                              ext_stall,
    output logic                              stall,
    output logic [NSRC*$clog2(DEPTH)-1:0]     fwd_sel,
    output logic [CNT_W-1:0]                  stall_cycles
);
    localparam int SELW = $clog2(DEPTH);

    logic [DEPTH-1:0]         t_v, t_regwr, t_load;
    logic [DEPTH-1:0][AW-1:0] t_rd;
    logic [NSRC*AW-1:0]       ex_src;
    logic [NSRC-1:0]          ex_use;
    logic                     bubble;

    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NSRC; i++)
            for (int k = 0; k < LOAD_LAT - 1; k++)
                if (t_v[k] && t_regwr[k] && t_load[k] && t_rd[k] != '0 &&
                    id_src_use[i] && t_rd[k] == id_src[i*AW +: AW])
                    stall = 1'b1;
        stall = stall && id_valid && !flush;
    end

    // Scan oldest to youngest so the youngest matching producer overwrites the select last
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++)
            for (int k = DEPTH - 1; k >= 1; k--)
                if (t_v[k] && t_regwr[k] && !(t_load[k] && k < LOAD_LAT) && t_rd[k] != '0 &&
                    ex_use[i] && t_rd[k] == ex_src[i*AW +: AW])
                    fwd_sel[i*SELW +: SELW] = SELW'(k);
    end

    assign bubble = !id_valid || flush || stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_v          <= '0;
            t_rd         <= '0;
            t_regwr      <= '0;
            t_load       <= '0;
            ex_src       <= '0;
            ex_use       <= '0;
            stall_cycles <= '0;
        end else if (!ext_stall) begin
            t_v     <= {t_v[DEPTH-2:0], !bubble};
            t_rd    <= {t_rd[DEPTH-2:0], id_rd};
            t_regwr <= {t_regwr[DEPTH-2:0], id_regwr};
            t_load  <= {t_load[DEPTH-2:0], id_load};
            ex_src  <= id_src;
            ex_use  <= bubble ? '0 : id_src_use;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule
